// File: rtl/cpu_mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store. Data requests
// win over fetches; a hung access is aborted after TIMEOUT wait cycles with bus_error.
module cpu_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        bus_error,
  output logic        stall,
  output logic [31:0] ram_addr,
  output logic        ram_read,
  output logic        ram_write,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_byteenable,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT_D = 2'd1;
  localparam logic [1:0] S_GRANT_I = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        own_d_q, own_d_d;
  logic        err_q, err_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic        ram_read_q, ram_read_d;
  logic        ram_write_q, ram_write_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic [3:0]  ram_be_q, ram_be_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  // Address bits [1:0] are dropped when forming the word address.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    own_d_d     = own_d_q;
    err_d       = err_q;
    ram_addr_d  = ram_addr_q;
    ram_read_d  = ram_read_q;
    ram_write_d = ram_write_q;
    ram_wdata_d = ram_wdata_q;
    ram_be_d    = ram_be_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        // Data first: it belongs to the older instruction in the pipeline.
        if (d_read | d_write) begin
          state_d     = S_GRANT_D;
          own_d_d     = 1'b1;
          err_d       = 1'b0;
          wcnt_d      = 16'd0;
          ram_addr_d  = {d_addr[31:2], 2'b00};
          ram_wdata_d = d_wdata;
          ram_be_d    = d_byteenable;
          ram_write_d = d_write;
          ram_read_d  = ~d_write;
        end else if (if_req) begin
          state_d     = S_GRANT_I;
          own_d_d     = 1'b0;
          err_d       = 1'b0;
          wcnt_d      = 16'd0;
          ram_addr_d  = {if_addr[31:2], 2'b00};
          ram_wdata_d = 32'h0;
          ram_be_d    = 4'b1111;
          ram_write_d = 1'b0;
          ram_read_d  = 1'b1;
        end
      end
      S_GRANT_D, S_GRANT_I: begin
        // An ack on the timeout cycle still counts as a normal completion.
        if (ram_ack || (wcnt_q == TIMEOUT_W)) begin
          state_d     = S_DONE;
          err_d       = ~ram_ack;
          ram_read_d  = 1'b0;
          ram_write_d = 1'b0;
          if (ram_read_q) begin
            if (own_d_q) d_rdata_d  = ram_ack ? ram_rdata : 32'h0;
            else         if_rdata_d = ram_ack ? ram_rdata : 32'h0;
          end
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wcnt_q      <= 16'd0;
      own_d_q     <= 1'b0;
      err_q       <= 1'b0;
      ram_addr_q  <= 32'h0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_wdata_q <= 32'h0;
      ram_be_q    <= 4'h0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      own_d_q     <= own_d_d;
      err_q       <= err_d;
      ram_addr_q  <= ram_addr_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ram_wdata_q <= ram_wdata_d;
      ram_be_q    <= ram_be_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_valid       = (state_q == S_DONE) & ~own_d_q;
  assign d_valid        = (state_q == S_DONE) & own_d_q;
  assign bus_error      = (state_q == S_DONE) & err_q;
  assign if_rdata       = if_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign ram_addr       = ram_addr_q;
  assign ram_read       = ram_read_q;
  assign ram_write      = ram_write_q;
  assign ram_wdata      = ram_wdata_q;
  assign ram_byteenable = ram_be_q;
  assign stall          = ((d_read | d_write) & ~d_valid) | (if_req & ~if_valid);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: scenario tasks plus randomized transactions, with
// expectations derived per transaction from the arbiter's timing and priority rules.
module tb_cpu_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        bus_error;
  logic        stall;
  logic [31:0] ram_addr;
  logic        ram_read;
  logic        ram_write;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_rdata;
  logic        ram_ack;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_if_rdata = 32'h0;
  logic [31:0] exp_d_rdata  = 32'h0;

  cpu_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_rdata(d_rdata), .d_valid(d_valid),
    .bus_error(bus_error), .stall(stall),
    .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write),
    .ram_wdata(ram_wdata), .ram_byteenable(ram_byteenable),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [139:0] outs;
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_read = 1'b0; d_write = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; d_byteenable = 4'h0; ram_rdata = 32'h0; ram_ack = 1'b0;
    tick; tick;
    outs = {if_rdata, if_valid, d_rdata, d_valid, bus_error, stall, ram_addr, ram_read,
            ram_write, ram_wdata, ram_byteenable};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", outs); end
    rst = 1'b0;
    exp_if_rdata = 32'h0; exp_d_rdata = 32'h0;
    tick;
    checks++;
    if ({if_valid, d_valid, ram_read, ram_write} !== 4'b0) begin
      errors++; $display("FAIL idle_after_reset got %b exp 0000", {if_valid, d_valid, ram_read, ram_write});
    end
  endtask

  // One complete access starting in an IDLE cycle; ack_wait<0 means no ack at all.
  task automatic do_access(input bit is_d, input bit wr, input bit rd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input int ack_wait,
                           input logic [31:0] rdata, input bit idle_ack);
    logic [71:0] exp_bus, got_bus;
    logic [31:0] exp_data;
    bit timed_out, is_read, got;
    int n, n_exp;
    timed_out = (ack_wait < 0) || (ack_wait > TO);
    is_read   = is_d ? !wr : 1'b1;
    n_exp     = timed_out ? TO : ack_wait;
    if (is_d) exp_bus = {addr[31:2], 2'b00, !wr, wr, be, wdata, 2'b00};
    else      exp_bus = {addr[31:2], 2'b00, 1'b1, 1'b0, 4'hF, 32'h0, 2'b00};
    if (is_d) begin
      d_read = rd; d_write = wr; d_addr = addr; d_wdata = wdata; d_byteenable = be;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    ram_ack = idle_ack; ram_rdata = $urandom;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL stall_on_request got %b exp 1", stall); end
    tick;
    got = 0; n = 0;
    while (!got && n <= TO + 2) begin
      got_bus = {ram_addr, ram_read, ram_write, ram_byteenable, ram_wdata, if_valid, d_valid};
      checks++;
      if (got_bus !== exp_bus) begin errors++; $display("FAIL grant_bus got %h exp %h", got_bus, exp_bus); end
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL stall_in_grant got %b exp 1", stall); end
      ram_ack   = (n == ack_wait);
      ram_rdata = (n == ack_wait) ? rdata : $urandom;
      tick;
      ram_ack = 1'b0;
      if (if_valid | d_valid) got = 1; else n++;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL completion got none exp valid after %0d waits", n_exp); end
    checks++;
    if (n !== n_exp) begin errors++; $display("FAIL latency got %0d exp %0d", n, n_exp); end
    exp_data = timed_out ? 32'h0 : rdata;
    if (is_read) begin
      if (is_d) exp_d_rdata = exp_data; else exp_if_rdata = exp_data;
    end
    checks++;
    if ({if_valid, d_valid, bus_error} !== {!is_d, is_d, timed_out}) begin
      errors++; $display("FAIL done_flags got %b exp %b", {if_valid, d_valid, bus_error}, {!is_d, is_d, timed_out});
    end
    checks++;
    if (d_rdata !== exp_d_rdata) begin errors++; $display("FAIL d_rdata got %h exp %h", d_rdata, exp_d_rdata); end
    if (!is_d) begin
      checks++;
      if (if_rdata !== exp_if_rdata) begin errors++; $display("FAIL if_rdata got %h exp %h", if_rdata, exp_if_rdata); end
    end
    checks++;
    if ({ram_read, ram_write, stall} !== 3'b000) begin
      errors++; $display("FAIL done_strobes got %b exp 000", {ram_read, ram_write, stall});
    end
    if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    tick;
    checks++;
    if ({if_valid, d_valid, bus_error, ram_read, ram_write} !== 5'b0) begin
      errors++; $display("FAIL idle_after got %b exp 00000", {if_valid, d_valid, bus_error, ram_read, ram_write});
    end
  endtask

  task automatic test_fetch;
    do_access(1'b0, 1'b0, 1'b0, 32'h00400006, 32'h0, 4'h0, 2, 32'h3C011234, 1'b0);
  endtask

  task automatic test_load;
    do_access(1'b1, 1'b0, 1'b1, 32'h10010004, 32'h0, 4'hF, 0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_timeout;
    do_access(1'b1, 1'b0, 1'b1, 32'h10010008, 32'h0, 4'hF, -1, 32'h12345678, 1'b0);
    do_access(1'b0, 1'b0, 1'b0, 32'h00400010, 32'h0, 4'h0, -1, 32'h11111111, 1'b0);
    do_access(1'b1, 1'b1, 1'b0, 32'h1001000C, 32'h55AA55AA, 4'b0011, -1, 32'h0, 1'b0);
  endtask

  task automatic test_ack_boundary;
    do_access(1'b1, 1'b0, 1'b1, 32'h10010010, 32'h0, 4'hF, TO, 32'hCAFEF00D, 1'b0);
  endtask

  task automatic test_simultaneous;
    if_req = 1'b1; if_addr = 32'h00400020;
    d_write = 1'b1; d_read = 1'b0; d_addr = 32'h10010000; d_byteenable = 4'b0100; d_wdata = 32'hABABABAB;
    #1;
    tick;
    checks++;
    if ({ram_addr, ram_read, ram_write, ram_byteenable, ram_wdata} !== {32'h10010000, 1'b0, 1'b1, 4'b0100, 32'hABABABAB}) begin
      errors++; $display("FAIL sim_data_grant got %h/%b%b/%b/%h", ram_addr, ram_read, ram_write, ram_byteenable, ram_wdata);
    end
    ram_ack = 1'b1; ram_rdata = 32'h99999999;
    tick;
    ram_ack = 1'b0;
    checks++;
    if ({d_valid, if_valid, bus_error, stall} !== 4'b1001) begin
      errors++; $display("FAIL sim_d_done got %b exp 1001", {d_valid, if_valid, bus_error, stall});
    end
    checks++;
    if (d_rdata !== exp_d_rdata) begin errors++; $display("FAIL sim_d_rdata got %h exp %h", d_rdata, exp_d_rdata); end
    d_write = 1'b0;
    tick;
    checks++;
    if ({stall, ram_read, ram_write} !== 3'b100) begin
      errors++; $display("FAIL sim_idle got %b exp 100", {stall, ram_read, ram_write});
    end
    tick;
    checks++;
    if ({ram_addr, ram_read, ram_write, ram_byteenable, ram_wdata} !== {32'h00400020, 1'b1, 1'b0, 4'hF, 32'h0}) begin
      errors++; $display("FAIL sim_fetch_grant got %h/%b%b/%b/%h", ram_addr, ram_read, ram_write, ram_byteenable, ram_wdata);
    end
    ram_ack = 1'b1; ram_rdata = 32'h24080001;
    tick;
    ram_ack = 1'b0;
    exp_if_rdata = 32'h24080001;
    checks++;
    if ({if_valid, d_valid, stall, if_rdata} !== {3'b100, 32'h24080001}) begin
      errors++; $display("FAIL sim_fetch_done got %b %h exp 100 24080001", {if_valid, d_valid, stall}, if_rdata);
    end
    if_req = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_access;
    logic [139:0] outs;
    if_req = 1'b1; if_addr = 32'h00400040;
    tick;
    checks++;
    if (ram_read !== 1'b1) begin errors++; $display("FAIL mid_grant got %b exp 1", ram_read); end
    rst = 1'b1; if_req = 1'b0;
    tick;
    rst = 1'b0;
    exp_if_rdata = 32'h0; exp_d_rdata = 32'h0;
    outs = {if_rdata, if_valid, d_rdata, d_valid, bus_error, stall, ram_addr, ram_read,
            ram_write, ram_wdata, ram_byteenable};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL mid_reset_outputs got %h exp 0", outs); end
    ram_ack = 1'b1; ram_rdata = 32'h77777777;
    tick;
    ram_ack = 1'b0;
    checks++;
    if ({if_valid, d_valid, bus_error, ram_read, ram_write} !== 5'b0) begin
      errors++; $display("FAIL stray_ack got %b exp 00000", {if_valid, d_valid, bus_error, ram_read, ram_write});
    end
    tick;
    checks++;
    if ({if_valid, d_valid, if_rdata} !== 34'h0) begin
      errors++; $display("FAIL stray_ack_late got %b %h exp 00 0", {if_valid, d_valid}, if_rdata);
    end
    do_access(1'b0, 1'b0, 1'b0, 32'h00400044, 32'h0, 4'h0, 0, 32'h8C880000, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [31:0] cur;
    int cyc, last, seen;
    cur = 32'h00401002; last = -1; seen = 0; cyc = 0;
    if_req = 1'b1; if_addr = cur;
    while (seen < 5 && cyc < 40) begin
      if (if_valid) begin
        checks++;
        if (if_rdata !== ({cur[31:2], 2'b00} ^ 32'h5A5A0000)) begin
          errors++; $display("FAIL b2b_data got %h exp %h", if_rdata, {cur[31:2], 2'b00} ^ 32'h5A5A0000);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 3) begin errors++; $display("FAIL b2b_period got %0d exp 3", cyc - last); end
        end
        last = cyc; seen++;
        cur = cur + 32'd4; if_addr = cur;
      end
      ram_ack = ram_read;
      ram_rdata = ram_addr ^ 32'h5A5A0000;
      tick;
      cyc++;
    end
    ram_ack = 1'b0;
    checks++;
    if (seen != 5) begin errors++; $display("FAIL b2b_count got %0d exp 5", seen); end
    exp_if_rdata = {cur[31:2] - 30'd1, 2'b00} ^ 32'h5A5A0000;
    if_req = 1'b0;
    tick; tick; tick;
  endtask

  task automatic test_random;
    int op, w;
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 3));
      w  = int'($urandom_range(0, 7)) - 1;
      case (op)
        0: do_access(1'b0, 1'b0, 1'b0, $urandom, 32'h0, 4'h0, w, $urandom, 1'($urandom));
        1: do_access(1'b1, 1'b0, 1'b1, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), w, $urandom, 1'($urandom));
        2: do_access(1'b1, 1'b1, 1'b0, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), w, $urandom, 1'($urandom));
        default: do_access(1'b1, 1'b1, 1'b1, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), w, $urandom, 1'($urandom));
      endcase
    end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_load;
    test_simultaneous;
    test_timeout;
    test_ack_boundary;
    test_back_to_back;
    test_reset_mid_access;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
